// File: rtl/ecg_bit_packer.sv
// Packs variable-length ECG beats (ECG bits then sign bits, MSB first) into OUT_WIDTH words.
// Optional macro ECG_PACK_BITCOUNT_EN adds the saturating total_bits output.
module ecg_bit_packer #(
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [49:0]          in_ecg,
  input  logic [5:0]           in_ecg_size,
  input  logic [3:0]           in_sign,
  input  logic [2:0]           in_sign_size,
  input  logic                 flush_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [6:0]           out_pad,
  output logic                 flush_done,
`ifdef ECG_PACK_BITCOUNT_EN
  output logic [23:0]          total_bits,
`endif
  output logic                 err
);

  // state   | meaning
  // S_RUN   | accepting beats, emitting full words
  // S_FLUSH | no input; draining, last word zero-padded
  // S_DONE  | flush_done pulse, back to S_RUN
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

  localparam int ACC_W  = OUT_WIDTH + 64;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] OW      = FILL_W'(OUT_WIDTH);
  localparam logic [FILL_W-1:0] RDY_MAX = FILL_W'(ACC_W - 54);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               err_q, err_d;

  logic               pop, accept, legal;
  logic [49:0]        ecg_al;
  logic [3:0]         sign_al;
  logic [53:0]        beat;
  logic [FILL_W-1:0]  beat_len;

  assign in_ready   = (state_q == S_RUN) && (fill_q <= RDY_MAX);
  assign out_valid  = (fill_q >= OW) || ((state_q == S_FLUSH) && (fill_q != '0));
  assign out_data   = acc_q[ACC_W-1 -: OUT_WIDTH];
  assign out_last   = (state_q == S_FLUSH) && (fill_q != '0) && (fill_q <= OW);
  assign out_pad    = out_last ? 7'(OW - fill_q) : 7'd0;
  assign flush_done = (state_q == S_DONE);
  assign err        = err_q;

  always_comb begin
    pop      = out_valid && out_ready;
    accept   = in_valid && in_ready;
    legal    = (in_ecg_size <= 6'd50) && (in_sign_size <= 3'd4);
    // Left-align each field so unused upper input bits fall off the top.
    ecg_al   = in_ecg << (6'd50 - in_ecg_size);
    sign_al  = in_sign << (3'd4 - in_sign_size);
    beat     = {ecg_al, 4'b0000} | ({sign_al, 50'd0} >> in_ecg_size);
    beat_len = FILL_W'(in_ecg_size) + FILL_W'(in_sign_size);

    acc_d   = acc_q;
    fill_d  = fill_q;
    err_d   = err_q;
    state_d = state_q;

    if (pop) begin
      acc_d  = acc_q << OUT_WIDTH;
      fill_d = (fill_q >= OW) ? (fill_q - OW) : '0;
    end

    // Append lands below the post-pop fill, so a held word is never disturbed.
    if (accept) begin
      if (legal) begin
        acc_d  = acc_d | ({beat, {(ACC_W-54){1'b0}}} >> fill_d);
        fill_d = fill_d + beat_len;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      S_RUN:   if (flush_req) state_d = S_FLUSH;
      S_FLUSH: if ((fill_q == '0) || (pop && (fill_q <= OW))) state_d = S_DONE;
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

`ifdef ECG_PACK_BITCOUNT_EN
  logic [23:0] cnt_q, cnt_d;
  logic [24:0] cnt_sum;

  always_comb begin
    cnt_sum = {1'b0, cnt_q} + 25'(beat_len);
    cnt_d   = cnt_q;
    if (state_q == S_DONE) begin
      cnt_d = '0;
    end else if (accept && legal) begin
      cnt_d = cnt_sum[24] ? '1 : cnt_sum[23:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign total_bits = cnt_q;
`endif

endmodule

// File: tb/tb_ecg_bit_packer.sv
// Bench for ecg_bit_packer: bit-queue scoreboard filled on accepted beats, drained on popped words.
module tb_ecg_bit_packer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, flush_req;
  logic [49:0]  in_ecg;
  logic [5:0]   in_ecg_size;
  logic [3:0]   in_sign;
  logic [2:0]   in_sign_size;
  logic         out_valid, out_ready, out_last, flush_done, err;
  logic [W-1:0] out_data;
  logic [6:0]   out_pad;
`ifdef ECG_PACK_BITCOUNT_EN
  logic [23:0]  total_bits;
`endif

  ecg_bit_packer #(.OUT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ecg(in_ecg), .in_ecg_size(in_ecg_size), .in_sign(in_sign),
    .in_sign_size(in_sign_size), .flush_req(flush_req), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_pad(out_pad), .flush_done(flush_done),
`ifdef ECG_PACK_BITCOUNT_EN
    .total_bits(total_bits),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: stream bits in order, plus a tiny flush sequencer.
  bit           bq[$];
  int           mstate = 0;
  bit           m_err = 0;
  int           m_bits = 0;
  logic [W-1:0] hist_data[$];
  bit           hist_last[$];
  int           hist_pad[$];

  always @(negedge clk) begin
    automatic int           n      = bq.size();
    automatic bit           ev     = (n >= W) || (mstate == 1 && n > 0);
    automatic bit           eready = (mstate == 0) && (n <= W + 64 - 54);
    automatic logic [W-1:0] wd     = '0;
    automatic bit           el     = (mstate == 1) && (n > 0) && (n <= W);
    automatic int           ep     = el ? W - n : 0;
    automatic int           nst    = mstate;
    automatic bit           pop;
    check_val("out_valid", out_valid, ev);
    check_val("in_ready", in_ready, eready);
    check_val("flush_done", flush_done, mstate == 2);
    check_val("err", err, m_err);
`ifdef ECG_PACK_BITCOUNT_EN
    check_val("total_bits", total_bits, m_bits);
`endif
    if (ev) begin
      for (int i = 0; i < W; i++) wd[W-1-i] = (i < n) ? bq[i] : 1'b0;
      check_val("out_data", out_data, wd);
      check_val("out_last", out_last, el);
      check_val("out_pad", out_pad, ep);
    end
    if (rst) begin
      bq.delete(); mstate = 0; m_err = 0; m_bits = 0;
    end else begin
      pop = ev && out_ready;
      if (pop) begin
        for (int i = 0; i < W && bq.size() > 0; i++) void'(bq.pop_front());
        hist_data.push_back(wd); hist_last.push_back(el); hist_pad.push_back(ep);
      end
      case (mstate)
        0: if (flush_req) nst = 1;
        1: if (n == 0 || (pop && n <= W)) nst = 2;
        default: nst = 0;
      endcase
      if (mstate == 2) m_bits = 0;
      if (in_valid && eready) begin
        if (in_ecg_size <= 50 && in_sign_size <= 4) begin
          for (int i = int'(in_ecg_size) - 1; i >= 0; i--) bq.push_back(in_ecg[i]);
          for (int i = int'(in_sign_size) - 1; i >= 0; i--) bq.push_back(in_sign[i]);
          m_bits = m_bits + int'(in_ecg_size) + int'(in_sign_size);
          if (m_bits > 24'hFFFFFF) m_bits = 24'hFFFFFF;
        end else begin
          m_err = 1;
        end
      end
      mstate = nst;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [49:0] e, input int es, input logic [3:0] s, input int ss);
    bit acc = 0;
    in_ecg = e; in_ecg_size = 6'(es); in_sign = s; in_sign_size = 3'(ss); in_valid = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_val("beat_accept", acc, 1);
  endtask

  task automatic flush();
    flush_req = 1'b1; idle(1); flush_req = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk); seen = flush_done;
    end
    check_val("flush_done_seen", seen, 1);
    idle(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    logic [W-1:0] held;
    rst = 1'b1; in_valid = 0; in_ecg = '0; in_ecg_size = '0; in_sign = '0;
    in_sign_size = '0; flush_req = 0; out_ready = 1'b1;
    idle(3);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_err", err, 0);
    rst = 1'b0;
    idle(1);

    // 11 x "110" -> first word DB6DB6DB, one bit left over
    for (int i = 0; i < 11; i++) beat(50'h3, 2, 4'h0, 1);
    idle(3);
    check_val("t1_words", hist_data.size(), 1);
    check_val("t1_word", hist_data[0], 32'hDB6DB6DB);
    flush(); wait_done();
    check_val("t1_tail_pad", hist_pad[hist_pad.size()-1], 31);

    // 50 ones + 4 zeros, flushed
    p0 = hist_data.size();
    beat({50{1'b1}}, 50, 4'h0, 4);
    flush(); wait_done();
    check_val("t2_words", hist_data.size() - p0, 2);
    check_val("t2_word0", hist_data[p0], 32'hFFFFFFFF);
    check_val("t2_word1", hist_data[p0+1], 32'hFFFFC000);
    check_val("t2_last", hist_last[p0+1], 1);
    check_val("t2_pad", hist_pad[p0+1], 10);

    // backpressure: a 54-bit beat blocks further input until a word pops
    out_ready = 1'b0;
    beat({50{1'b1}}, 50, 4'hF, 4);
    @(negedge clk);
    check_val("bp_in_ready", in_ready, 0);
    held = out_data;
    idle(5);
    @(negedge clk);
    check_val("bp_hold", out_data, held);
    idle(1);
    fork
      beat(50'h2AAAA_AAAA_AAAA, 50, 4'h5, 4);
      begin idle(4); out_ready = 1'b1; end
    join
    flush(); wait_done();

    // illegal size dropped, err sticky, next beat packs normally
    p0 = hist_data.size();
    beat(50'h3FFFF_FFFF_FFFF, 51, 4'hF, 4);
    @(negedge clk);
    check_val("ill_err", err, 1);
    check_val("ill_no_bits", out_valid, 0);
    idle(1);
    beat(50'h1234, 16, 4'hA, 4);
    flush(); wait_done();
    check_val("ill_next_word", hist_data[p0], 32'h1234A000);

    // flush with nothing pending: done two cycles after the request
    p0 = hist_data.size();
    flush();
    @(negedge clk); check_val("empty_done_c1", flush_done, 0);
    @(negedge clk); check_val("empty_done_c2", flush_done, 1);
    idle(1);
    check_val("empty_no_word", hist_data.size() - p0, 0);

    // exactly 64 bits pending at flush
    out_ready = 1'b0;
    beat(50'hDEADBEEF, 32, 4'h0, 0);
    beat(50'h12345678, 32, 4'h0, 0);
    p0 = hist_data.size();
    flush();
    out_ready = 1'b1;
    wait_done();
    check_val("f64_words", hist_data.size() - p0, 2);
    check_val("f64_last", hist_last[p0+1], 1);
    check_val("f64_pad", hist_pad[p0+1], 0);
    check_val("f64_w1", hist_data[p0+1], 32'h12345678);

    // reset in the middle of a flush with 40 bits pending
    out_ready = 1'b0;
    beat(50'hFF_FFFF_FFFF, 40, 4'h0, 0);
    flush(); idle(2);
    rst = 1'b1; idle(1);
    check_val("rst_mid_valid", out_valid, 0);
    check_val("rst_mid_ready", in_ready, 1);
    check_val("rst_mid_done", flush_done, 0);
`ifdef ECG_PACK_BITCOUNT_EN
    check_val("rst_mid_bits", total_bits, 0);
`endif
    rst = 1'b0; out_ready = 1'b1;
    beat(50'h5, 3, 4'h1, 1);
    flush(); wait_done();
    idle(3);
    check_val("sb_drained", bq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
